// File: rtl/traffic_phase_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_scheduler_if
// Brief    : Request, lamp and debug bundle for the intersection phase scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface traffic_phase_scheduler_if;
    logic       tick;
    logic       ns_req;
    logic       ew_req;
    logic       ped_req;
    logic       ns_g;
    logic       ns_y;
    logic       ns_r;
    logic       ew_g;
    logic       ew_y;
    logic       ew_r;
    logic       walk;
    logic       ped_pending;
    logic [2:0] phase;

    modport master (
        output tick, ns_req, ew_req, ped_req,
        input  ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_pending, phase
    );

    modport slave (
        input  tick, ns_req, ew_req, ped_req,
        output ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_pending, phase
    );
endinterface
`default_nettype wire

// File: rtl/traffic_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_scheduler
// Brief    : Actuated NS/EW/pedestrian phase scheduler with min/max green.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_phase_scheduler #(
    parameter int G_MIN      = 3,
    parameter int G_MAX      = 8,
    parameter int Y_TICKS    = 2,
    parameter int AR_TICKS   = 1,
    parameter int WALK_TICKS = 4,
    parameter int CW         = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    traffic_phase_scheduler_if.slave   bus
);

    localparam logic [2:0] c_ns_g    = 3'd0;
    localparam logic [2:0] c_ns_y    = 3'd1;
    localparam logic [2:0] c_ew_g    = 3'd2;
    localparam logic [2:0] c_ew_y    = 3'd3;
    localparam logic [2:0] c_all_red = 3'd4;
    localparam logic [2:0] c_walk    = 3'd5;

    localparam logic       c_road_ns = 1'b0;
    localparam logic       c_road_ew = 1'b1;

    localparam logic [CW-1:0] c_g_min_last = CW'(G_MIN - 1);
    localparam logic [CW-1:0] c_g_max_last = CW'(G_MAX - 1);
    localparam logic [CW-1:0] c_y_last     = CW'(Y_TICKS - 1);
    localparam logic [CW-1:0] c_ar_last    = CW'(AR_TICKS - 1);
    localparam logic [CW-1:0] c_walk_last  = CW'(WALK_TICKS - 1);
    localparam logic [CW-1:0] c_cnt_max    = {CW{1'b1}};

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [CW-1:0] r_phase_cnt;
    logic          r_last_road;
    logic          r_prev_walk;
    logic          r_ped_pending;

    logic          w_at_gmin;
    logic          w_at_gmax;
    logic          w_state_change;
    logic [6:0]    w_lamps;

    assign w_at_gmin      = (r_phase_cnt >= c_g_min_last);
    assign w_at_gmax      = (r_phase_cnt >= c_g_max_last);
    assign w_state_change = (w_next != r_state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ns_g;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ns_g: begin
                if (bus.tick && w_at_gmin && (bus.ew_req || r_ped_pending) &&
                    (!bus.ns_req || w_at_gmax)) begin
                    w_next = c_ns_y;
                end
            end
            c_ew_g: begin
                if (bus.tick && w_at_gmin && (bus.ns_req || r_ped_pending) &&
                    (!bus.ew_req || w_at_gmax)) begin
                    w_next = c_ew_y;
                end
            end
            c_ns_y, c_ew_y: begin
                if (bus.tick && (r_phase_cnt == c_y_last)) begin
                    w_next = c_all_red;
                end
            end
            c_walk: begin
                if (bus.tick && (r_phase_cnt == c_walk_last)) begin
                    w_next = c_all_red;
                end
            end
            c_all_red: begin
                // A walk is never granted twice in a row through one clearance
                if (bus.tick && (r_phase_cnt == c_ar_last)) begin
                    if (r_ped_pending && !r_prev_walk) begin
                        w_next = c_walk;
                    end else if (r_last_road == c_road_ns) begin
                        w_next = c_ew_g;
                    end else begin
                        w_next = c_ns_g;
                    end
                end
            end
            default: w_next = c_all_red;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase_cnt   <= '0;
            r_last_road   <= c_road_ns;
            r_prev_walk   <= 1'b0;
            r_ped_pending <= 1'b0;
        end else begin
            if (w_state_change) begin
                r_phase_cnt <= '0;
                r_prev_walk <= (r_state == c_walk);
            end else if (bus.tick && (r_phase_cnt != c_cnt_max)) begin
                r_phase_cnt <= r_phase_cnt + 1'b1;
            end

            if (w_next == c_ns_g) begin
                r_last_road <= c_road_ns;
            end else if (w_next == c_ew_g) begin
                r_last_road <= c_road_ew;
            end

            // Requests arriving during or on entry to a walk are already served
            if ((w_next == c_walk) && (r_state != c_walk)) begin
                r_ped_pending <= 1'b0;
            end else if (bus.ped_req && (r_state != c_walk)) begin
                r_ped_pending <= 1'b1;
            end
        end
    end

    // Lamp order: ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk
    always_comb begin
        w_lamps = 7'b001_001_0;
        case (r_state)
            c_ns_g:    w_lamps = 7'b100_001_0;
            c_ns_y:    w_lamps = 7'b010_001_0;
            c_ew_g:    w_lamps = 7'b001_100_0;
            c_ew_y:    w_lamps = 7'b001_010_0;
            c_all_red: w_lamps = 7'b001_001_0;
            c_walk:    w_lamps = 7'b001_001_1;
            default:   w_lamps = 7'b001_001_0;
        endcase
    end

    assign bus.ns_g        = w_lamps[6];
    assign bus.ns_y        = w_lamps[5];
    assign bus.ns_r        = w_lamps[4];
    assign bus.ew_g        = w_lamps[3];
    assign bus.ew_y        = w_lamps[2];
    assign bus.ew_r        = w_lamps[1];
    assign bus.walk        = w_lamps[0];
    assign bus.ped_pending = r_ped_pending;
    assign bus.phase       = r_state;

endmodule
`default_nettype wire

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
Demand-driven phase scheduler for a two-road intersection with a pedestrian crossing. It replaces fixed-time NS/EW cycling with actuated control:
- minimum and maximum green times
- an all-red clearance interval
- arbitration between NS traffic, EW traffic and a latched pedestrian request.
It consumes the 1 Hz tick strobe and drives all lamp outputs plus a walk signal.

Parameters:
G_MIN, 3, minimum green duration in ticks (>=1)
G_MAX, 8, maximum green duration in ticks when own road still has demand (>=G_MIN)
Y_TICKS, 2, yellow duration in ticks (>=1)
AR_TICKS, 1, all-red clearance duration in ticks (>=1)
WALK_TICKS, 4, pedestrian walk duration in ticks (>=1)
CW, 4, phase counter width; every duration parameter must be <= 2^CW-1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
tick  in  1  one-cycle timing strobe (1 Hz)
ns_req  in  1  NS vehicle presence (level)
ew_req  in  1  EW vehicle presence (level)
ped_req  in  1  pedestrian button (one-cycle pulse)
ns_g, ns_y, ns_r  out  1 each  NS lamps
ew_g, ew_y, ew_r  out  1 each  EW lamps
walk  out  1  pedestrian walk lamp
ped_pending  out  1  latched pedestrian request
phase  out  3  current state encoding (debug)

Behaviour:
- Clock and reset: single clock domain; all state on posedge clk. Reset is asynchronous and active-high.
- Reset values:
  - state=NS_G, phase_cnt=0, last_road=NS, ped_pending=0.
  - Outputs: ns_g=1, ew_r=1, all other lamps 0, walk=0, phase=0.
- States and phase encodings: NS_G=0, NS_Y=1, EW_G=2, EW_Y=3, ALL_RED=4, WALK=5. Encodings 6 and 7 are illegal and recover to ALL_RED on the next clk.
- Outputs are Moore (decoded from state only):
  - NS_G: ns_g, ew_r
  - NS_Y: ns_y, ew_r
  - EW_G: ew_g, ns_r
  - EW_Y: ew_y, ns_r
  - ALL_RED: ns_r, ew_r
  - WALK: ns_r, ew_r, walk
  - Exactly one lamp per road is lit at all times.
- Phase counter (phase_cnt):
  - Clears on every state change.
  - Otherwise increments on tick, saturating at 2^CW-1.
  - "Nth tick of a phase" means a tick arriving while phase_cnt==N-1.
  - A transition decided on a tick takes effect on the same clk edge, so the new state is visible the cycle after the tick.
- Green (NS_G shown; EW_G is symmetric with roads swapped):
  - conflict = ew_req | ped_pending
  - On a tick with phase_cnt >= G_MIN-1 and conflict=1: go to NS_Y if ns_req=0, or if phase_cnt >= G_MAX-1. Otherwise stay (extension).
  - conflict=0: hold green indefinitely.
- NS_Y / EW_Y: go to ALL_RED on the Y_TICKS-th tick.
- WALK: go to ALL_RED on the WALK_TICKS-th tick.
- ALL_RED exit, on the AR_TICKS-th tick:
  - If ped_pending=1 and the preceding state was not WALK: go to WALK.
  - Otherwise go to the green of the road opposite last_road.
  - last_road updates on entry to NS_G or EW_G.
  - A 1-bit prev_walk flag records the preceding state.
- Pedestrian latch:
  - ped_req sets ped_pending.
  - Entry into WALK clears it.
  - ped_req while in WALK, or on the entry clk edge into WALK, is dropped (that request is already being served).
- Simultaneous events:
  - tick with a request change: requests are sampled in the same cycle as the tick.
  - ped_req on the same cycle as a green-exit tick counts as conflict only from the next cycle (latched first).
- Reset mid-phase: immediate return to reset values regardless of clk or tick.

Test Plan:
1. Reset with ns_req=1, ew_req=0, ped_req=0, 20 ticks -> stays NS_G (phase=0), ns_g=1, ew_r=1 throughout.
2. From NS_G with ns_req=0, assert ew_req=1 before the 3rd tick -> NS_Y the cycle after the 3rd tick; ALL_RED after 2 more ticks; EW_G after 1 more tick; last_road=EW.
3. Hold ns_req=1 and ew_req=1 from reset -> NS_G lasts exactly 8 ticks (G_MAX), then NS_Y.
4. Pulse ped_req in NS_G with ns_req=0 -> ped_pending=1; NS_G exits at tick 3 -> NS_Y (2 ticks) -> ALL_RED (1) -> WALK with walk=1 for 4 ticks, ped_pending=0 -> ALL_RED -> EW_G (opposite of last_road=NS).
5. Pulse ped_req during WALK -> ped_pending stays 0; no second WALK follows.
6. Assert rst asynchronously mid-EW_Y, between clk edges -> outputs return to ns_g=1, ew_r=1, phase=0 before the next clk edge; phase_cnt=0.
